div32_seq: RTL and testbench

DIV32_SEQ -- requirements
Module: div32_seq

---
 rtl/div32_seq_if.sv | 22 ++
 rtl/div32_seq.sv | 96 +++++++++
 tb/tb_div32_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/div32_seq_if.sv
// Request/result bundle for the sequential 32-bit unsigned divider.
// The master drives operands and start; the slave (divider) returns results and status.
interface div32_seq_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        dz;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, dz
  );
endinterface

// File: rtl/div32_seq.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Define DIV32_ZERO_FASTPATH_EN to finish divide-by-zero one edge after accept.
module div32_seq (
  input  logic        clk,
  input  logic        rst,
  div32_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd;   // dividend shifts out MSB-first while quotient bits shift in
  logic [31:0] r_dvs;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_rmd;
  logic        r_done;
  logic        r_busy;
  logic        r_dz;

  logic [32:0] w_partial;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;

  // A kept difference is always below the divisor, so 32 bits of it are exact.
  assign w_partial  = {r_rem, r_dvd[31]};
  assign w_ge       = (w_partial >= {1'b0, r_dvs});
  assign w_sub      = w_partial[31:0] - r_dvs;
  assign w_rem_next = w_ge ? w_sub : w_partial[31:0];
  assign w_quo_next = {r_dvd[30:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_rem <= w_rem_next;
          r_dvd <= w_quo_next;
          r_cnt <= r_cnt + 5'd1;
`ifdef DIV32_ZERO_FASTPATH_EN
          if (r_dvs == '0) begin
            r_quo   <= '1;
            r_rmd   <= r_dvd;
            r_dz    <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else
`endif
          if (r_cnt == 5'd31) begin
            r_quo   <= w_quo_next;
            r_rmd   <= w_rem_next;
            r_dz    <= (r_dvs == '0);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          if (bus.start) begin
            r_dvd   <= bus.dividend;
            r_dvs   <= bus.divisor;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.quotient  = r_quo;
  assign bus.remainder = r_rmd;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.dz        = r_dz;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases plus random operands
// against an arithmetic reference model.
module tb_div32_seq;

`ifdef DIV32_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 32;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  div32_seq_if bus ();

  div32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive start for exactly one edge; returns 1 time unit after the accept edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("accept_busy", {31'd0, bus.busy}, 32'd1);
    chk("accept_done", {31'd0, bus.done}, 32'd0);
  endtask

  // Wait for done after an accept; optionally re-pulse start (to be ignored) before edge `inject`.
  task automatic wait_done(input logic [31:0] a, input logic [31:0] b, input int inject, input bit tail);
    logic [31:0] exp_q, exp_r;
    logic        exp_dz;
    int          exp_lat;
    int          edges;
    bit          seen;
    exp_dz  = (b == 0);
    exp_q   = exp_dz ? 32'hFFFF_FFFF : a / b;
    exp_r   = exp_dz ? a : a % b;
    exp_lat = exp_dz ? ZLAT : 32;
    edges   = 0;
    seen    = 1'b0;
    while (!seen && edges < 100) begin
      if (edges + 1 == inject) begin
        bus.start    = 1'b1;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      edges++;
      if (bus.done) begin
        seen = 1'b1;
      end else if (edges == 1 || edges == 16) begin
        chk("run_busy", {31'd0, bus.busy}, 32'd1);
        chk("run_q_hold", bus.quotient, last_q);
        chk("run_r_hold", bus.remainder, last_r);
        chk("run_dz_clr", {31'd0, bus.dz}, 32'd0);
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", edges, exp_lat);
    chk("quotient", bus.quotient, exp_q);
    chk("remainder", bus.remainder, exp_r);
    chk("dz", {31'd0, bus.dz}, {31'd0, exp_dz});
    chk("done_busy", {31'd0, bus.busy}, 32'd0);
    $display("op %h / %h -> q=%h r=%h dz=%0d after %0d edges", a, b,
             bus.quotient, bus.remainder, bus.dz, edges);
    last_q = exp_q;
    last_r = exp_r;
    if (tail) begin
      @(posedge clk);
      #1;
      chk("done_pulse_end", {31'd0, bus.done}, 32'd0);
      chk("q_after_done", bus.quotient, exp_q);
      chk("dz_after_done", {31'd0, bus.dz}, {31'd0, exp_dz});
    end
  endtask

  initial begin
    logic [31:0] a, b;
    int pulses;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #2 rst = 1'b1;
    #1;
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_flags", {29'd0, bus.done, bus.busy, bus.dz}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic operation
    accept(32'd100, 32'd7);
    wait_done(32'd100, 32'd7, 0, 1'b1);

    // Back-to-back with start held into the DONE cycle
    accept(32'hFFFF_FFFF, 32'd1);
    wait_done(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    accept(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);

    // Divide by zero
    accept(32'd12345, 32'd0);
    wait_done(32'd12345, 32'd0, 0, 1'b1);

    // Start while busy must be ignored
    accept(32'd987654321, 32'd1234);
    wait_done(32'd987654321, 32'd1234, 10, 1'b1);

    // Asynchronous reset in the middle of a run
    accept(32'hDEAD_BEEF, 32'd77);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
    end
    #4 rst = 1'b1;
    #1;
    chk("midrst_q", bus.quotient, 32'd0);
    chk("midrst_r", bus.remainder, 32'd0);
    chk("midrst_flags", {29'd0, bus.done, bus.busy, bus.dz}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    last_q = '0;
    last_r = '0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("no_done_after_abort", pulses, 32'd0);
    accept(32'd9, 32'd3);
    wait_done(32'd9, 32'd3, 0, 1'b1);

    // Random operands
    for (int n = 0; n < 12; n++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(1, 15);
        1: b = $urandom;
        2: begin a = $urandom_range(0, 1000); b = $urandom; end
        3: b = 32'd0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      accept(a, b);
      wait_done(a, b, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
